alu_share_arbiter: RTL

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_share_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Two requesters share one multi-cycle ALU, with one operation in flight at a time.
// Each operation takes an accept cycle, LAT issue cycles and a response cycle; the response is held until it is consumed.
module alu_share_arbiter #(
  parameter int W   = 32,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic [2:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  input  logic [2:0]   req1_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_cin,
  output logic [2:0]   alu_op,
  input  logic [W:0]   alu_r,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W:0]   rsp_r,
  output logic         rsp_zero,
  output logic         rsp_ovf,
  output logic         rsp_err,
  output logic         busy
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ISSUE = 2'b01;
  localparam logic [1:0] S_RESP  = 2'b10;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;
  localparam logic [2:0] LAT_CNT = 3'(LAT);

  logic [1:0]   r_state;
  logic         r_last_grant;
  logic [2:0]   r_cnt;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic         r_cin;
  logic [2:0]   r_op;
  logic         r_id;
  logic [W:0]   r_rsp_r;
  logic         r_zero;
  logic         r_ovf;
  logic         r_err;

  logic         w_any_vld;
  logic         w_gnt;
  logic         w_acc;
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic         w_cin;
  logic [2:0]   w_op;
  logic         w_ovf;

  // On contention the requester that did not win last time gets the grant.
  assign w_any_vld = req0_valid | req1_valid;
  assign w_gnt     = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
  assign w_acc     = (r_state == S_IDLE) & w_any_vld;

  assign w_a   = w_gnt ? req1_a   : req0_a;
  assign w_b   = w_gnt ? req1_b   : req0_b;
  assign w_cin = w_gnt ? req1_cin : req0_cin;
  assign w_op  = w_gnt ? req1_op  : req0_op;

  // Readies are forced low while reset is held so nothing looks accepted.
  assign req0_ready = rst_n & w_acc & ~w_gnt;
  assign req1_ready = rst_n & w_acc &  w_gnt;

  assign w_ovf = (alu_r[W-1] & ~r_a[W-1] & ~r_b[W-1]) |
                 (~alu_r[W-1] & r_a[W-1] & r_b[W-1]);

  // The operand registers drive the ALU directly, so an illegal op must not load them.
  assign alu_a   = r_a;
  assign alu_b   = r_b;
  assign alu_cin = r_cin;
  assign alu_op  = r_op;

  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_id;
  assign rsp_r     = r_rsp_r;
  assign rsp_zero  = r_zero;
  assign rsp_ovf   = r_ovf;
  assign rsp_err   = r_err;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_cin        <= 1'b0;
      r_op         <= '0;
      r_id         <= 1'b0;
      r_rsp_r      <= '0;
      r_zero       <= 1'b0;
      r_ovf        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_last_grant <= w_gnt;
            r_id         <= w_gnt;
            if (w_op == OP_ILLEGAL) begin
              r_rsp_r <= '0;
              r_zero  <= 1'b0;
              r_ovf   <= 1'b0;
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_a     <= w_a;
              r_b     <= w_b;
              r_cin   <= w_cin;
              r_op    <= w_op;
              r_cnt   <= LAT_CNT;
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_rsp_r <= alu_r;
            r_zero  <= (alu_r == '0);
            r_ovf   <= w_ovf;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
